aes_128_encipher: RTL and testbench
===================================

AES_128_ENCIPHER -- requirements
Module: aes_128_encipher

Interface
- REQ-001 The block SHALL have one parameter: NUM_ROUNDS, default 10, the number of AES-128 cipher rounds (fixed, not overridable).
- REQ-002 clk  input  1  single clock; all registers SHALL update on its rising edge.
- REQ-003 reset_n  input  1  reset, asynchronous and active-low.
- REQ-004 next  input  1  start request, sampled in IDLE only.
- REQ-005 key_ready  input  1  key memory ready flag; round keys 0..10 valid when high.
- REQ-006 block  input  128  plaintext, sampled on the accepting edge.
- REQ-007 round_key  input  128  key for the round index currently on round.
- REQ-008 new_sbox  input  32  S-box substituted word for the word currently on sbox.
- REQ-009 round  output  4  round-key index to the key memory.
- REQ-010 sbox  output  32  state word presented for substitution.
- REQ-011 new_block  output  128  ciphertext, registered.
- REQ-012 ready  output  1  high when idle and the result is valid.
- REQ-013 err  output  1  sticky start-without-key flag (see Configuration).

Function
- REQ-014 The FSM SHALL have the states IDLE, INIT, SBOX, MAIN and DONE.
- REQ-015 IDLE SHALL go to INIT when next=1 and key_ready=1; this edge is the accepting edge: latch block, clear ready, clear the round counter.
- REQ-016 INIT SHALL hold round=0, write state = block ^ round_key, set round counter to 1, and go to SBOX.
- REQ-017 SBOX SHALL take 4 cycles, word w=0..3 (w0=[127:96]); sbox=state word w; at each edge that word is replaced by new_sbox; after w=3 go to MAIN.
- REQ-018 MAIN SHALL write state = AddRoundKey(MixColumns(ShiftRows(state))) with round=counter; in round NUM_ROUNDS, MixColumns SHALL be omitted.
- REQ-019 From MAIN: if counter<NUM_ROUNDS, increment the counter and go to SBOX; else go to DONE.
- REQ-020 DONE SHALL copy state to new_block, set ready=1, and go to IDLE.
- REQ-021 Latency: ready SHALL rise at the 52nd rising edge after the accepting edge (1 INIT cycle + 10 rounds of 5 cycles + 1 DONE cycle).
- REQ-022 round SHALL be 0 in IDLE and INIT and equal to the counter in SBOX and MAIN; sbox SHALL be 0 outside SBOX.
- REQ-023 next SHALL be ignored in all states other than IDLE; a request held high SHALL restart from IDLE on the edge after DONE.
- REQ-024 new_block SHALL hold its value until the next DONE.
- REQ-025 next=1 with key_ready=0 in IDLE SHALL NOT start an operation.

Reset
- REQ-026 reset_n low SHALL, asynchronously and at any state including mid-operation, force: FSM=IDLE, counter=0, word index=0, state=0, new_block=0, ready=1, err=0.
- REQ-027 No partial result SHALL survive reset.

Configuration
- REQ-028 With AES_128_ENC_KEYCHK_EN defined, a rejected start (REQ-025) SHALL set err=1; err SHALL stay set until reset or the next accepted start.
- REQ-029 Without AES_128_ENC_KEYCHK_EN, err SHALL be tied to 0 and the rejected start SHALL be silently ignored.

Structure
- REQ-030 The shared package aes_128_pkg SHALL hold: NUM_ROUNDS, the FSM state encodings, and the GF(2^8) xtime and multiply functions.
- REQ-031 ShiftRows SHALL be implemented as pure wiring inside this block.
- REQ-032 One sub-module, aes_128_mixw, SHALL implement single-column MixColumns and SHALL be instantiated 4 times.
- REQ-033 The S-box SHALL remain external and shared through sbox/new_sbox.

Verification
- REQ-034 Apply FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff -> new_block 69c4e0d86a7b0430d8cdb78070b4c55a, with ready high exactly 52 edges after the accepting edge.
- REQ-035 Apply FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, block 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; the state after INIT SHALL be 193de3bea0f4e22b9ac68d2ae9f84808.
- REQ-036 Pulse next at cycles 10 and 30 after the start -> no restart, the result is unchanged, and exactly one ready rise occurs.
- REQ-037 Assert reset_n low at cycle 25 of an operation -> ready=1, new_block=0, round=0 immediately; a fresh C.1 run then completes correctly.
- REQ-038 Drive next=1 with key_ready=0 -> ready stays 1 and no state change occurs; err=1 if AES_128_ENC_KEYCHK_EN is defined, else 0; a following valid start clears err.
- REQ-039 Run back-to-back C.1 and App.B operations with next held high -> both results are correct, with 53 cycles from one ready rise to the next.

Source files
------------

// File: rtl/aes_128_pkg.sv
// aes_128_pkg: shared constants, FSM state encoding and GF(2^8) helpers
// for the AES-128 encipher datapath.
package aes_128_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned ROUND_W    = 4;
  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned WORD_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_SBOX = 3'd2,
    ST_MAIN = 3'd3,
    ST_DONE = 3'd4
  } aes_state_e;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_128_mixw.sv
// aes_128_mixw: MixColumns applied to one 32-bit state column.
// Ports:
//   col     - input column, byte 0 in [31:24]
//   mixed_c - combinational mixed column
module aes_128_mixw
  import aes_128_pkg::*;
(
  input  logic [WORD_W-1:0] col,
  output logic [WORD_W-1:0] mixed_c
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col[31:24];
  assign a1 = col[23:16];
  assign a2 = col[15:8];
  assign a3 = col[7:0];

  assign mixed_c = {
    gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3,
    a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3,
    a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03),
    gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02)
  };

endmodule

// File: rtl/aes_128_encipher.sv
// aes_128_encipher: iterative AES-128 encryption core. One INIT cycle,
// then per round four S-box cycles (one word each, through the external
// shared S-box) and one ShiftRows/MixColumns/AddRoundKey cycle, then DONE.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   next          - start request (IDLE only), key_ready - round keys valid
//   block         - plaintext, round_key - key for index on 'round'
//   new_sbox      - substituted word for the word on 'sbox'
//   round, sbox   - key-memory index and word to the S-box
//   new_block     - registered ciphertext, ready - idle with valid result
//   err           - sticky start-without-key flag
// Build option: define AES_128_ENC_KEYCHK_EN to enable err; otherwise err = 0.
module aes_128_encipher
  import aes_128_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               next,
  input  logic               key_ready,
  input  logic [BLOCK_W-1:0] block,
  input  logic [BLOCK_W-1:0] round_key,
  input  logic [WORD_W-1:0]  new_sbox,
  output logic [ROUND_W-1:0] round,
  output logic [WORD_W-1:0]  sbox,
  output logic [BLOCK_W-1:0] new_block,
  output logic               ready,
  output logic               err
);

  aes_state_e         fsm_q, fsm_d;
  logic [ROUND_W-1:0] cnt_q, cnt_d;
  logic [1:0]         w_q, w_d;
  logic [BLOCK_W-1:0] st_q, st_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [BLOCK_W-1:0] nb_q, nb_d;
  logic               rdy_q, rdy_d;
  logic [BLOCK_W-1:0] sr_w, mc_w;
  logic [WORD_W-1:0]  cur_word;
  logic               accept_c;

  assign accept_c = (fsm_q == ST_IDLE) && next && key_ready;

  // ShiftRows as wiring (column-major state, byte 0 in MSBs), then MixColumns per column.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr_w[BLOCK_W-1-8*(r+4*c) -: 8] = st_q[BLOCK_W-1-8*(r+4*((c+r)%4)) -: 8];
    end
    aes_128_mixw u_mixw (
      .col     (sr_w[BLOCK_W-1-WORD_W*c -: WORD_W]),
      .mixed_c (mc_w[BLOCK_W-1-WORD_W*c -: WORD_W])
    );
  end

  // State word currently being substituted.
  always_comb begin
    cur_word = st_q[127:96];
    case (w_q)
      2'd0:    cur_word = st_q[127:96];
      2'd1:    cur_word = st_q[95:64];
      2'd2:    cur_word = st_q[63:32];
      default: cur_word = st_q[31:0];
    endcase
  end

  assign round     = (fsm_q == ST_SBOX || fsm_q == ST_MAIN) ? cnt_q : '0;
  assign sbox      = (fsm_q == ST_SBOX) ? cur_word : '0;
  assign new_block = nb_q;
  assign ready     = rdy_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q <= ST_IDLE;
      cnt_q <= '0;
      w_q   <= '0;
      st_q  <= '0;
      blk_q <= '0;
      nb_q  <= '0;
      rdy_q <= 1'b1;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      w_q   <= w_d;
      st_q  <= st_d;
      blk_q <= blk_d;
      nb_q  <= nb_d;
      rdy_q <= rdy_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    w_d   = w_q;
    st_d  = st_q;
    blk_d = blk_q;
    nb_d  = nb_q;
    rdy_d = rdy_q;
    case (fsm_q)
      ST_IDLE: begin
        if (accept_c) begin
          fsm_d = ST_INIT;
          blk_d = block;
          rdy_d = 1'b0;
          cnt_d = '0;
        end
      end
      ST_INIT: begin
        st_d  = blk_q ^ round_key;
        cnt_d = ROUND_W'(1);
        w_d   = '0;
        fsm_d = ST_SBOX;
      end
      ST_SBOX: begin
        case (w_q)
          2'd0:    st_d[127:96] = new_sbox;
          2'd1:    st_d[95:64]  = new_sbox;
          2'd2:    st_d[63:32]  = new_sbox;
          default: st_d[31:0]   = new_sbox;
        endcase
        w_d = w_q + 2'd1;
        if (w_q == 2'd3) fsm_d = ST_MAIN;
      end
      ST_MAIN: begin
        // Final round skips MixColumns.
        st_d = ((cnt_q == ROUND_W'(NUM_ROUNDS)) ? sr_w : mc_w) ^ round_key;
        if (cnt_q < ROUND_W'(NUM_ROUNDS)) begin
          cnt_d = cnt_q + ROUND_W'(1);
          fsm_d = ST_SBOX;
        end else begin
          fsm_d = ST_DONE;
        end
      end
      ST_DONE: begin
        nb_d  = st_q;
        rdy_d = 1'b1;
        fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

`ifdef AES_128_ENC_KEYCHK_EN
  logic err_q;

  // Sticky until reset or the next accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (accept_c) begin
      err_q <= 1'b0;
    end else if (fsm_q == ST_IDLE && next && !key_ready) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_128_encipher.sv
// tb_aes_128_encipher: scoreboard bench for aes_128_encipher with a bench-side
// S-box, key memory and byte-level AES reference model.
module tb_aes_128_encipher;

  localparam int LAT = 52;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] IB = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
`ifdef AES_128_ENC_KEYCHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         next = 1'b0;
  logic         key_ready = 1'b0;
  logic [127:0] block = '0;
  logic [127:0] round_key;
  logic [31:0]  new_sbox;
  logic [3:0]   round;
  logic [31:0]  sbox;
  logic [127:0] new_block;
  logic         ready;
  logic         err;

  aes_128_encipher dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .next      (next),
    .key_ready (key_ready),
    .block     (block),
    .round_key (round_key),
    .new_sbox  (new_sbox),
    .round     (round),
    .sbox      (sbox),
    .new_block (new_block),
    .ready     (ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]   sbt    [0:255];
  logic [127:0] rk_mem [0:15];

  assign round_key = rk_mem[round];
  assign new_sbox  = {sbt[sbox[31:24]], sbt[sbox[23:16]], sbt[sbox[15:8]], sbt[sbox[7:0]]};

  typedef struct {
    logic [127:0] exp;
    int           t;
  } sb_t;
  sb_t sb_q[$];

  logic         rdy_prev = 1'b1;
  logic [127:0] last_nb = '0;
  int           last_rise = 0;
  int           prev_rise = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = m2(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbt[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = m2(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_mem[r] = (r < 11) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // Byte-array AES-128 using the currently loaded round keys.
  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] k;
    logic [127:0] o;
    k = rk_mem[0];
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbt[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
          s[4*c+3] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      k = rk_mem[rnd];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Monitor: on each ready rise pop and check result and latency; otherwise new_block must hold.
  always @(negedge clk) begin
    sb_t e;
    if (!reset_n) begin
      rdy_prev = 1'b1;
      last_nb  = '0;
    end else begin
      if (ready && !rdy_prev) begin
        if (sb_q.size() == 0) begin
          chk("spurious_ready", 128'(1), 128'(0));
        end else begin
          e = sb_q.pop_front();
          chk("ciphertext", new_block, e.exp);
          chk("latency", 128'(cyc - e.t), 128'(LAT));
          last_nb   = e.exp;
          prev_rise = last_rise;
          last_rise = cyc;
        end
      end else begin
        chk("hold", new_block, last_nb);
      end
      rdy_prev = ready;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_idle", 128'(ready), 128'(1));
  endtask

  task automatic wait_rise();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_rise", 128'(ready), 128'(1));
  endtask

  // Issue a start; returns at #1 after the accepting edge (the INIT cycle).
  task automatic start(input logic [127:0] key, input logic [127:0] pt,
                       input bit kat, input logic [127:0] kat_val, input bit hold);
    sb_t e;
    wait_idle();
    load_key(key);
    block     = pt;
    key_ready = 1'b1;
    next      = 1'b1;
    e.exp     = kat ? kat_val : aes_ref(pt);
    @(posedge clk); #1;
    e.t = cyc;
    sb_q.push_back(e);
    chk("err_after_accept", 128'(err), 128'(0));
    if (!hold) next = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] rk, rp;
    sb_t e;
    build_sbox();
    for (int r = 0; r < 16; r++) rk_mem[r] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 128'(ready), 128'(1));
    chk("rst_new_block", new_block, 128'(0));
    chk("rst_round", 128'(round), 128'(0));
    chk("rst_sbox", 128'(sbox), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;

    // App.B, observing the post-INIT state through the S-box port
    start(KB, PB, 1'b1, CB, 1'b0);
    chk("init_round", 128'(round), 128'(0));
    chk("init_sbox", 128'(sbox), 128'(0));
    for (int w = 0; w < 4; w++) begin
      @(posedge clk); #1;
      rk = IB;
      chk("init_state_word", 128'(sbox), 128'(rk[127-32*w -: 32]));
      chk("sbox_round", 128'(round), 128'(1));
    end
    wait_idle();

    // C.1
    start(KC, PC, 1'b1, CC, 1'b0);
    wait_idle();

    // next pulses mid-operation are ignored
    start(KC, PC, 1'b1, CC, 1'b0);
    repeat (9) @(posedge clk);
    #1 next = 1'b1;
    @(posedge clk); #1 next = 1'b0;
    repeat (19) @(posedge clk);
    #1 next = 1'b1;
    @(posedge clk); #1 next = 1'b0;
    wait_idle();

    // Reset mid-operation, then a fresh C.1
    start(KB, PB, 1'b1, CB, 1'b0);
    repeat (25) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_ready", 128'(ready), 128'(1));
    chk("midrst_new_block", new_block, 128'(0));
    chk("midrst_round", 128'(round), 128'(0));
    chk("midrst_sbox", 128'(sbox), 128'(0));
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    start(KC, PC, 1'b1, CC, 1'b0);
    wait_idle();

    // Rejected start without key
    key_ready = 1'b0;
    next      = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("reject_ready", 128'(ready), 128'(1));
      chk("reject_round", 128'(round), 128'(0));
      chk("reject_err", 128'(err), 128'(EXP_ERR));
    end
    next = 1'b0;
    @(posedge clk); #1;
    chk("reject_err_sticky", 128'(err), 128'(EXP_ERR));
    rk = {$urandom, $urandom, $urandom, $urandom};
    rp = {$urandom, $urandom, $urandom, $urandom};
    start(rk, rp, 1'b0, 128'(0), 1'b0);
    wait_idle();

    // Back-to-back with next held: C.1 then App.B
    start(KC, PC, 1'b1, CC, 1'b1);
    wait_rise();
    load_key(KB);
    block = PB;
    e.exp = CB;
    e.t   = cyc + 1;
    sb_q.push_back(e);
    @(posedge clk); #1 next = 1'b0;
    wait_rise();
    @(negedge clk); #1;
    chk("b2b_gap", 128'(last_rise - prev_rise), 128'(LAT + 1));

    // Random keys and plaintexts
    for (int i = 0; i < 6; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      start(rk, rp, 1'b0, 128'(0), 1'b0);
      wait_idle();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 128'(sb_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
